// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the MEM stage (result source, funct3 widths, MEM FSM states).
package pipeline_pkg;
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LANES = 4;
  typedef enum logic {IDLE, WAIT_R} mau_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-enable/lane replication and load lane extract with sign/zero extension.
module lsu_lane_align
  import pipeline_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      store_data,
  input  logic [31:0]      rdata,
  output logic [LANES-1:0] be,
  output logic [31:0]      wdata,
  output logic [31:0]      load_data
);
  logic       is_b, is_h;
  logic [7:0] b;
  logic [15:0] h;
  // funct3[2] selects zero extension; any non-byte, non-half code is handled as a word
  always_comb begin
    is_b = funct3[1:0] == 2'b00;
    is_h = funct3[1:0] == 2'b01;
    be = is_b ? 4'b0001 << addr_lo : is_h ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
    wdata = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = is_b ? {{24{b[7] & !funct3[2]}}, b} : is_h ? {{16{h[15] & !funct3[2]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage - one req/gnt/rvalid data access per load/store, stall control, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: suppress misaligned accesses and flag them on MisalignW.
module mem_access_unit
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  StallM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [DATA_WIDTH-1:0] ReadDataW
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  MisalignW
`endif
);
  mau_state_t state, state_next;
  logic access, misalign, go;
  logic [DATA_WIDTH-1:0] load_data;

  assign access = MemWriteM | (ResultSrcM == RES_LOAD);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & ((funct3M[1:0] == 2'b01 & ALUResultM[0]) | (funct3M[1] & |ALUResultM[1:0]));
`else
  assign misalign = 1'b0;
`endif
  // requests are only raised from IDLE and never while reset is held
  assign go = rst & (state == IDLE) & access & !misalign;

  lsu_lane_align u_align (
    .funct3    (funct3M),
    .addr_lo   (ALUResultM[1:0]),
    .store_data(WriteDataM),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .load_data (load_data)
  );

  assign dmem_req  = go;
  assign dmem_we   = go & MemWriteM;
  assign dmem_addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    StallM = (state == WAIT_R) ? !dmem_rvalid : go & (!dmem_gnt | !MemWriteM);
    state_next = (state == WAIT_R) ? (dmem_rvalid ? IDLE : WAIT_R) :
                 (go & dmem_gnt & !MemWriteM) ? WAIT_R : IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      RegWriteW  <= 1'b0;
      ResultSrcW <= RES_ALU;
      RdW        <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      ReadDataW  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      RegWriteW  <= RegWriteM & !StallM & !misalign;
      ResultSrcW <= StallM ? RES_ALU : ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      if (state == WAIT_R && dmem_rvalid) ReadDataW <= load_data;
`ifdef MEM_MISALIGN_TRAP_EN
      MisalignW  <= misalign;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the MEM stage (ALU pass-through, stores, loads, back-to-back, reset abort).
module tb_mem_access_unit;
  import pipeline_pkg::*;
  logic clk = 0, rst = 0;
  logic RegWriteM, MemWriteM, StallM, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, RegWriteW;
  logic [1:0] ResultSrcM, ResultSrcW;
  logic [2:0] funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] ALUResultW, PCPlus4W, ReadDataW;
  logic [4:0] RdM, RdW;
  logic [3:0] dmem_be;
`ifdef MEM_MISALIGN_TRAP_EN
  logic MisalignW;
`endif

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
  } wb_t;

  wb_t q[$];
  wb_t exp_w;
  logic [31:0] model_rdata = 0;
  int total = 0, bad = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
    .PCPlus4W(PCPlus4W), .ReadDataW(ReadDataW)
`ifdef MEM_MISALIGN_TRAP_EN
    , .MisalignW(MisalignW)
`endif
  );

  always #5 clk = ~clk;

  function automatic wb_t w_obs();
    return {RegWriteW, ResultSrcW, RdW, ALUResultW, PCPlus4W, ReadDataW};
  endfunction

  task automatic set_instr(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = a; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
  endtask

  task automatic test_reset();
    set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (w_obs() !== '0) begin bad++; $display("FAIL reset_w got=%h want=0", w_obs()); end
    set_instr(1, RES_LOAD, 0, F3_W, 32'h40, 0, 3, 4);
    #1;
    total++; if ({dmem_req, StallM} !== 2'b00) begin bad++; $display("FAIL reset_req_stall got=%b want=00", {dmem_req, StallM}); end
    set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_alu();
    for (int i = 0; i < 2; i++) begin
      set_instr(1, i ? RES_PC4 : RES_ALU, 0, F3_W, 32'h1234_5678 + i, 32'hFFFF, 5'd5 + 5'(i), 32'h44 + 32'(i));
      q.push_back(wb_t'({1'b1, i ? RES_PC4 : RES_ALU, 5'd5 + 5'(i), 32'h1234_5678 + 32'(i), 32'h44 + 32'(i), model_rdata}));
      #1;
      total++; if ({StallM, dmem_req} !== 2'b00) begin bad++; $display("FAIL alu_stall_req got=%b want=00", {StallM, dmem_req}); end
      @(posedge clk); #1;
      exp_w = q.pop_front();
      total++; if (w_obs() !== exp_w) begin bad++; $display("FAIL alu_w got=%h want=%h", w_obs(), exp_w); end
    end
  endtask

  logic [2:0]  st_f3[5] = '{F3_B, F3_H, F3_W, 3'b011, F3_B};
  logic [31:0] st_a[5]  = '{32'h103, 32'h102, 32'h100, 32'h108, 32'h100};
  logic [31:0] st_d[5]  = '{32'h0000_00AB, 32'h1234_BEEF, 32'hCAFE_F00D, 32'h0102_0304, 32'h0000_005A};
  logic [3:0]  st_be[5] = '{4'b1000, 4'b1100, 4'b1111, 4'b1111, 4'b0001};
  logic [31:0] st_w[5]  = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'hCAFE_F00D, 32'h0102_0304, 32'h5A5A_5A5A};

  task automatic test_store();
    for (int i = 0; i < 5; i++) begin
      set_instr(0, RES_ALU, 1, st_f3[i], st_a[i], st_d[i], 0, 32'h200 + 32'(i));
      dmem_gnt = 1;
      q.push_back(wb_t'({1'b0, RES_ALU, 5'd0, st_a[i], 32'h200 + 32'(i), model_rdata}));
      #1;
      total++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, StallM} !==
          {1'b1, 1'b1, st_a[i][31:2], 2'b00, st_be[i], st_w[i], 1'b0}) begin
        bad++;
        $display("FAIL store_bus[%0d] got req=%b we=%b addr=%h be=%b wdata=%h stall=%b want addr=%h be=%b wdata=%h",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, StallM, {st_a[i][31:2], 2'b00}, st_be[i], st_w[i]);
      end
      @(posedge clk); #1;
      dmem_gnt = 0;
      exp_w = q.pop_front();
      total++; if (w_obs() !== exp_w) begin bad++; $display("FAIL store_w[%0d] got=%h want=%h", i, w_obs(), exp_w); end
    end
    set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
  endtask

  logic [2:0]  ld_f3[7] = '{F3_B, F3_HU, F3_H, F3_BU, F3_W, F3_H, F3_B};
  logic [31:0] ld_a[7]  = '{32'h102, 32'h202, 32'h202, 32'h101, 32'h404, 32'h200, 32'h103};
  logic [31:0] ld_r[7]  = '{32'h0080_FF00, 32'h8001_1234, 32'h8001_1234, 32'h1234_F078, 32'hDEAD_BEEF,
                            32'h8001_7FFF, 32'h7F00_0000};
  logic [31:0] ld_e[7]  = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_00F0, 32'hDEAD_BEEF,
                            32'h0000_7FFF, 32'h0000_007F};
  int          ld_gd[7] = '{0, 0, 1, 0, 4, 0, 0};
  int          ld_rv[7] = '{2, 0, 1, 0, 0, 1, 0};

  task automatic test_load();
    int stalls;
    for (int i = 0; i < 7; i++) begin
      set_instr(1, RES_LOAD, 0, ld_f3[i], ld_a[i], 0, 5'd10 + 5'(i), 32'h1000 + 32'(4 * i));
      dmem_gnt = 0;
      stalls = 0;
      for (int c = 0; c < ld_gd[i]; c++) begin
        #1;
        stalls += int'(StallM);
        total++;
        if ({dmem_req, dmem_addr, StallM} !== {1'b1, ld_a[i][31:2], 2'b00, 1'b1}) begin
          bad++; $display("FAIL load_nognt[%0d] got req=%b addr=%h stall=%b", i, dmem_req, dmem_addr, StallM);
        end
        @(posedge clk); #1;
      end
      dmem_gnt = 1;
      #1;
      stalls += int'(StallM);
      total++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, ld_a[i][31:2], 2'b00}) begin
        bad++; $display("FAIL load_req[%0d] got req=%b we=%b addr=%h", i, dmem_req, dmem_we, dmem_addr);
      end
      @(posedge clk); #1;
      dmem_gnt = 0;
      for (int c = 0; c < ld_rv[i]; c++) begin
        #1;
        stalls += int'(StallM);
        total++;
        if ({StallM, dmem_req, RegWriteW, ResultSrcW} !== 5'b10000) begin
          bad++; $display("FAIL load_wait[%0d] got stall=%b req=%b rw=%b rs=%b want 1 0 0 00", i, StallM, dmem_req, RegWriteW, ResultSrcW);
        end
        @(posedge clk); #1;
      end
      dmem_rvalid = 1; dmem_rdata = ld_r[i];
      model_rdata = ld_e[i];
      q.push_back(wb_t'({1'b1, RES_LOAD, 5'd10 + 5'(i), ld_a[i], 32'h1000 + 32'(4 * i), model_rdata}));
      #1;
      total++;
      if ({StallM, dmem_req, RegWriteW} !== 3'b000) begin
        bad++; $display("FAIL load_rvalid[%0d] got stall=%b req=%b rw=%b want 000", i, StallM, dmem_req, RegWriteW);
      end
      total++;
      if (stalls !== ld_gd[i] + 1 + ld_rv[i]) begin
        bad++; $display("FAIL load_stall_cycles[%0d] got=%0d want=%0d", i, stalls, ld_gd[i] + 1 + ld_rv[i]);
      end
      @(posedge clk); #1;
      dmem_rvalid = 0; dmem_rdata = 0;
      set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
      exp_w = q.pop_front();
      total++; if (w_obs() !== exp_w) begin bad++; $display("FAIL load_w[%0d] got=%h want=%h", i, w_obs(), exp_w); end
    end
  endtask

  task automatic test_back_to_back();
    set_instr(0, RES_ALU, 1, F3_W, 32'h500, 32'h1122_3344, 0, 32'h600);
    dmem_gnt = 1;
    q.push_back(wb_t'({1'b0, RES_ALU, 5'd0, 32'h500, 32'h600, model_rdata}));
    #1;
    total++; if ({dmem_req, StallM} !== 2'b10) begin bad++; $display("FAIL b2b_store got req=%b stall=%b", dmem_req, StallM); end
    @(posedge clk); #1;
    exp_w = q.pop_front();
    total++; if (w_obs() !== exp_w) begin bad++; $display("FAIL b2b_store_w got=%h want=%h", w_obs(), exp_w); end
    set_instr(1, RES_LOAD, 0, F3_W, 32'h500, 0, 9, 32'h604);
    #1;
    total++; if ({dmem_req, dmem_we, StallM} !== 3'b101) begin bad++; $display("FAIL b2b_load_issue got req=%b we=%b stall=%b", dmem_req, dmem_we, StallM); end
    @(posedge clk); #1;
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h1122_3344;
    model_rdata = 32'h1122_3344;
    q.push_back(wb_t'({1'b1, RES_LOAD, 5'd9, 32'h500, 32'h604, model_rdata}));
    @(posedge clk); #1;
    dmem_rvalid = 0; dmem_rdata = 0;
    exp_w = q.pop_front();
    total++; if (w_obs() !== exp_w) begin bad++; $display("FAIL b2b_load_w got=%h want=%h", w_obs(), exp_w); end
    set_instr(1, RES_ALU, 0, F3_W, 32'h77, 0, 7, 32'h608);
    q.push_back(wb_t'({1'b1, RES_ALU, 5'd7, 32'h77, 32'h608, model_rdata}));
    #1;
    total++; if ({dmem_req, StallM} !== 2'b00) begin bad++; $display("FAIL b2b_alu got req=%b stall=%b", dmem_req, StallM); end
    @(posedge clk); #1;
    exp_w = q.pop_front();
    total++; if (w_obs() !== exp_w) begin bad++; $display("FAIL b2b_alu_w got=%h want=%h", w_obs(), exp_w); end
    set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
  endtask

  task automatic test_reset_wait_r();
    set_instr(1, RES_LOAD, 0, F3_B, 32'h100, 0, 4, 32'h700);
    dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    #1;
    total++; if ({StallM, dmem_req} !== 2'b10) begin bad++; $display("FAIL rstw_wait got stall=%b req=%b want 10", StallM, dmem_req); end
    rst = 0;
    model_rdata = 0;
    q.delete();
    #1;
    total++; if (w_obs() !== '0) begin bad++; $display("FAIL rstw_w got=%h want=0", w_obs()); end
    total++; if ({StallM, dmem_req} !== 2'b00) begin bad++; $display("FAIL rstw_outs got stall=%b req=%b want 00", StallM, dmem_req); end
    set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    total++; if ({StallM, dmem_req} !== 2'b00) begin bad++; $display("FAIL rstw_stray got stall=%b req=%b want 00", StallM, dmem_req); end
    @(posedge clk); #1;
    dmem_rvalid = 0; dmem_rdata = 0;
    total++; if (w_obs() !== '0) begin bad++; $display("FAIL rstw_stray_w got=%h want=0", w_obs()); end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    set_instr(1, RES_LOAD, 0, F3_W, 32'h101, 0, 6, 32'h800);
    #1;
    total++; if ({dmem_req, StallM} !== 2'b00) begin bad++; $display("FAIL mis_req got req=%b stall=%b want 00", dmem_req, StallM); end
    @(posedge clk); #1;
    set_instr(0, RES_ALU, 0, F3_W, 0, 0, 0, 0);
    total++; if ({MisalignW, RegWriteW} !== 2'b10) begin bad++; $display("FAIL mis_flag got mis=%b rw=%b want 10", MisalignW, RegWriteW); end
    @(posedge clk); #1;
    total++; if (MisalignW !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b want=0", MisalignW); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_wait_r();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
